aq_axis_line_framer: RTL and testbench

- Sits directly downstream of aq_axis_reduce and consumes its reduced ARGB stream plus FSYNC_OUT.
- The reduce output marks only end-of-frame with TLAST. This block re-frames that stream to AXI4-Stream Video convention: TUSER marks start-of-frame, TLAST marks end-of-line.
- It checks the pixel count against the configured output geometry, then drops or truncates to recover from malformed frames.
- Feeds VDMA/display stages.

---
 rtl/aq_axis_line_framer.sv | 207 ++++++++++++++++++++
 tb/tb_aq_axis_line_framer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aq_axis_line_framer.sv
// Re-frames the reduced ARGB stream to AXI4-Stream Video (TUSER=SOF, TLAST=EOL) and polices frame geometry.
// Latency 1 cycle through a fully registered 2-entry skid buffer; S_AXIS_TREADY drops only when both entries are occupied.
module aq_axis_line_framer #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 12
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic [CNT_WIDTH-1:0]  CFG_WIDTH,
    input  logic [CNT_WIDTH-1:0]  CFG_HEIGHT,
    input  logic                  FSYNC_IN,
    input  logic [DATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic                  S_AXIS_TLAST,
    input  logic                  S_AXIS_TVALID,
    output logic                  S_AXIS_TREADY,
    output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                  M_AXIS_TUSER,
    output logic                  M_AXIS_TLAST,
    output logic                  M_AXIS_TVALID,
    input  logic                  M_AXIS_TREADY,
    output logic                  FRAME_DONE,
    output logic                  ERR_SHORT,
    output logic                  ERR_LONG
);

    typedef enum logic [1:0] {IDLE, RUN, DROP} state_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] dat;
        logic                  user;
        logic                  last;
        logic                  eof;
    } beat_t;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] w_m1_q, w_m1_d, h_m1_q, h_m1_d;
    logic [CNT_WIDTH-1:0] x_q, x_d, y_q, y_d;
    logic                 sof_q, sof_d;
    beat_t                head_q, head_d, skid_q, skid_d, push_beat;
    logic                 head_vld_q, head_vld_d, skid_vld_q, skid_vld_d;
    logic                 rdy_q, rdy_d;
    logic                 done_q, done_d, err_s_q, err_s_d, err_l_q, err_l_d;
    logic                 s_fire, m_pop, push, cfg_ok, run_ctx, frame_end;
    logic [CNT_WIDTH-1:0] cw, ch, cx, cy;
    logic                 csof;

    // Frame context (cw/ch/cx/cy/csof) is the latched one, or a fresh one when FSYNC
    // lands in RUN, so a pixel accepted alongside FSYNC starts the new frame.
    always_comb begin
        cfg_ok    = (CFG_WIDTH != '0) && (CFG_HEIGHT != '0);
        s_fire    = S_AXIS_TVALID && rdy_q;
        state_d   = state_q;
        w_m1_d    = w_m1_q;
        h_m1_d    = h_m1_q;
        x_d       = x_q;
        y_d       = y_q;
        sof_d     = sof_q;
        err_s_d   = 1'b0;
        err_l_d   = 1'b0;
        cw        = w_m1_q;
        ch        = h_m1_q;
        cx        = x_q;
        cy        = y_q;
        csof      = sof_q;
        run_ctx   = 1'b0;
        frame_end = 1'b0;
        push      = 1'b0;
        push_beat = '0;
        case (state_q)
            IDLE, DROP: begin
                if (FSYNC_IN && cfg_ok) begin
                    w_m1_d  = CFG_WIDTH - 1'b1;
                    h_m1_d  = CFG_HEIGHT - 1'b1;
                    x_d     = '0;
                    y_d     = '0;
                    sof_d   = 1'b1;
                    state_d = RUN;
                end else if (state_q == DROP && s_fire && S_AXIS_TLAST) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                run_ctx = 1'b1;
                if (FSYNC_IN) begin
                    err_s_d = 1'b1;
                    if (cfg_ok) begin
                        cw   = CFG_WIDTH - 1'b1;
                        ch   = CFG_HEIGHT - 1'b1;
                        cx   = '0;
                        cy   = '0;
                        csof = 1'b1;
                    end else begin
                        run_ctx = 1'b0;
                        state_d = IDLE;
                    end
                end
                if (run_ctx) begin
                    w_m1_d = cw;
                    h_m1_d = ch;
                    x_d    = cx;
                    y_d    = cy;
                    sof_d  = csof;
                    if (s_fire) begin
                        frame_end      = (cx == cw) && (cy == ch);
                        push           = 1'b1;
                        push_beat.dat  = S_AXIS_TDATA;
                        push_beat.user = csof;
                        push_beat.last = (cx == cw) || S_AXIS_TLAST;
                        push_beat.eof  = frame_end || S_AXIS_TLAST;
                        sof_d          = 1'b0;
                        if (cx == cw) begin
                            x_d = '0;
                            y_d = cy + 1'b1;
                        end else begin
                            x_d = cx + 1'b1;
                        end
                        if (frame_end) begin
                            if (S_AXIS_TLAST) begin
                                state_d = IDLE;
                            end else begin
                                err_l_d = 1'b1;
                                state_d = DROP;
                            end
                        end else if (S_AXIS_TLAST) begin
                            err_s_d = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Skid buffer: head drives M_AXIS_*, skid catches the beat accepted while head stalls.
    always_comb begin
        m_pop      = head_vld_q && M_AXIS_TREADY;
        head_d     = head_q;
        head_vld_d = head_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (!head_vld_q || m_pop) begin
            if (skid_vld_q) begin
                head_d     = skid_q;
                head_vld_d = 1'b1;
                skid_vld_d = push;
                if (push) begin
                    skid_d = push_beat;
                end
            end else begin
                head_vld_d = push;
                if (push) begin
                    head_d = push_beat;
                end
            end
        end else if (push) begin
            skid_d     = push_beat;
            skid_vld_d = 1'b1;
        end
        done_d = m_pop && head_q.eof;
        rdy_d  = (state_d == DROP) || (state_d == RUN && !(head_vld_d && skid_vld_d));
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q    <= IDLE;
            w_m1_q     <= '0;
            h_m1_q     <= '0;
            x_q        <= '0;
            y_q        <= '0;
            sof_q      <= 1'b0;
            head_q     <= '0;
            skid_q     <= '0;
            head_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            rdy_q      <= 1'b0;
            done_q     <= 1'b0;
            err_s_q    <= 1'b0;
            err_l_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            w_m1_q     <= w_m1_d;
            h_m1_q     <= h_m1_d;
            x_q        <= x_d;
            y_q        <= y_d;
            sof_q      <= sof_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
            head_vld_q <= head_vld_d;
            skid_vld_q <= skid_vld_d;
            rdy_q      <= rdy_d;
            done_q     <= done_d;
            err_s_q    <= err_s_d;
            err_l_q    <= err_l_d;
        end
    end

    assign S_AXIS_TREADY = rdy_q;
    assign M_AXIS_TDATA  = head_q.dat;
    assign M_AXIS_TUSER  = head_q.user;
    assign M_AXIS_TLAST  = head_q.last;
    assign M_AXIS_TVALID = head_vld_q;
    assign FRAME_DONE    = done_q;
    assign ERR_SHORT     = err_s_q;
    assign ERR_LONG      = err_l_q;

endmodule

// File: tb/tb_aq_axis_line_framer.sv
// Scoreboard bench for aq_axis_line_framer: driver queues expected beats, negedge monitor pops and compares.
module tb_aq_axis_line_framer;
    localparam int DW = 32;
    localparam int CW = 12;

    logic          ACLK = 1'b0;
    logic          ARESETN = 1'b0;
    logic [CW-1:0] CFG_WIDTH = '0;
    logic [CW-1:0] CFG_HEIGHT = '0;
    logic          FSYNC_IN = 1'b0;
    logic [DW-1:0] S_AXIS_TDATA = '0;
    logic          S_AXIS_TLAST = 1'b0;
    logic          S_AXIS_TVALID = 1'b0;
    logic          S_AXIS_TREADY;
    logic [DW-1:0] M_AXIS_TDATA;
    logic          M_AXIS_TUSER;
    logic          M_AXIS_TLAST;
    logic          M_AXIS_TVALID;
    logic          M_AXIS_TREADY = 1'b1;
    logic          FRAME_DONE;
    logic          ERR_SHORT;
    logic          ERR_LONG;

    aq_axis_line_framer #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .CFG_WIDTH(CFG_WIDTH), .CFG_HEIGHT(CFG_HEIGHT), .FSYNC_IN(FSYNC_IN),
        .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TLAST(S_AXIS_TLAST),
        .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TREADY(S_AXIS_TREADY),
        .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TUSER(M_AXIS_TUSER), .M_AXIS_TLAST(M_AXIS_TLAST),
        .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TREADY(M_AXIS_TREADY),
        .FRAME_DONE(FRAME_DONE), .ERR_SHORT(ERR_SHORT), .ERR_LONG(ERR_LONG)
    );

    always #5 ACLK = ~ACLK;

    typedef struct packed {
        logic [DW-1:0] dat;
        logic          user;
        logic          last;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    int          chk_cnt = 0;
    int          pass_cnt = 0;
    int          cnt_done = 0, cnt_es = 0, cnt_el = 0, cnt_last = 0, gaps = 0;
    int          cyc = 0, prev_cyc = 0;
    bit          rand_en = 1'b0, tp_en = 1'b0, have_prev = 1'b0;
    logic        prev_stall = 1'b0;
    logic [33:0] prev_out = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(posedge ACLK) cyc++;

    always @(posedge ACLK) begin
        #1;
        M_AXIS_TREADY = rand_en ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    // Inputs change at posedge+1, so values seen at negedge decide the next edge's transfers.
    always @(negedge ACLK) begin
        if (ARESETN) begin
            if (prev_stall)
                check("stall_hold", {M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TUSER, M_AXIS_TLAST}, {1'b1, prev_out});
            if (M_AXIS_TVALID && M_AXIS_TREADY) begin
                check("out_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("out_beat", {M_AXIS_TDATA, M_AXIS_TUSER, M_AXIS_TLAST}, e);
                end
                cnt_last += int'(M_AXIS_TLAST);
                if (tp_en) begin
                    if (have_prev && cyc != prev_cyc + 1) gaps++;
                    have_prev = 1'b1;
                    prev_cyc  = cyc;
                end
            end
            if (!tp_en) have_prev = 1'b0;
            prev_stall = M_AXIS_TVALID && !M_AXIS_TREADY;
            prev_out   = {M_AXIS_TDATA, M_AXIS_TUSER, M_AXIS_TLAST};
            cnt_done  += int'(FRAME_DONE);
            cnt_es    += int'(ERR_SHORT);
            cnt_el    += int'(ERR_LONG);
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic send_px(input logic [DW-1:0] d, input logic l, input bit push_exp,
                           input logic eu, input logic el);
        int t = 0;
        S_AXIS_TVALID = 1'b1;
        S_AXIS_TDATA  = d;
        S_AXIS_TLAST  = l;
        @(negedge ACLK);
        while (!S_AXIS_TREADY && t < 1000) begin
            @(negedge ACLK);
            t++;
        end
        if (t >= 1000) check("accept_timeout", S_AXIS_TREADY, 1);
        if (push_exp && S_AXIS_TREADY) exp_q.push_back({d, eu, el});
        @(posedge ACLK);
        #1;
    endtask

    task automatic idle_in();
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TLAST  = 1'b0;
    endtask

    task automatic fsync(input int w, input int h);
        CFG_WIDTH  = CW'(w);
        CFG_HEIGHT = CW'(h);
        FSYNC_IN   = 1'b1;
        @(posedge ACLK);
        #1;
        FSYNC_IN   = 1'b0;
    endtask

    task automatic run_frame(input int w, input int n, input int tl, input int nexp, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++)
            send_px(base + DW'(i), i == tl, i < nexp, i == 0, ((i % w) == w - 1) || (i == tl));
        idle_in();
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 20000) begin
            @(posedge ACLK);
            t++;
        end
        repeat (3) @(posedge ACLK);
        #1;
        check("drain", exp_q.size(), 0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", pass_cnt, chk_cnt);
        $fatal(1);
    end

    initial begin
        int d0, s0, l0, t0, g0;
        repeat (3) @(posedge ACLK);
        #1;
        check("rst_tvalid", M_AXIS_TVALID, 0);
        check("rst_tready", S_AXIS_TREADY, 0);
        check("rst_flags", {M_AXIS_TUSER, M_AXIS_TLAST, FRAME_DONE, ERR_SHORT, ERR_LONG, M_AXIS_TDATA}, 0);
        ARESETN = 1'b1;
        @(posedge ACLK);
        #1;

        // 48x48 full frame, back-to-back
        d0 = cnt_done; s0 = cnt_es; l0 = cnt_el; t0 = cnt_last; g0 = gaps;
        tp_en = 1'b1;
        fsync(48, 48);
        run_frame(48, 2304, 2303, 2304, 32'h0100_0000);
        wait_drain();
        tp_en = 1'b0;
        check("f48_done", cnt_done - d0, 1);
        check("f48_err", {cnt_es - s0, cnt_el - l0}, 0);
        check("f48_tlast", cnt_last - t0, 48);
        check("f48_gaps", gaps - g0, 0);

        // 48x48 with random output stalls
        d0 = cnt_done; s0 = cnt_es; l0 = cnt_el; t0 = cnt_last;
        rand_en = 1'b1;
        fsync(48, 48);
        run_frame(48, 2304, 2303, 2304, 32'h0200_0000);
        wait_drain();
        rand_en = 1'b0;
        repeat (2) @(posedge ACLK);
        #1;
        check("stall_done", cnt_done - d0, 1);
        check("stall_err", {cnt_es - s0, cnt_el - l0}, 0);
        check("stall_tlast", cnt_last - t0, 48);

        // 4x4 short frame: 10 pixels
        d0 = cnt_done; s0 = cnt_es; l0 = cnt_el; t0 = cnt_last;
        fsync(4, 4);
        run_frame(4, 10, 9, 10, 32'h0300_0000);
        wait_drain();
        check("short_es", cnt_es - s0, 1);
        check("short_el", cnt_el - l0, 0);
        check("short_done", cnt_done - d0, 1);
        check("short_tlast", cnt_last - t0, 3);
        check("short_idle_rdy", S_AXIS_TREADY, 0);

        // 4x4 long frame: 20 pixels, last 4 dropped
        s0 = cnt_es; l0 = cnt_el; t0 = cnt_last;
        fsync(4, 4);
        run_frame(4, 20, 19, 16, 32'h0400_0000);
        wait_drain();
        check("long_el", cnt_el - l0, 1);
        check("long_es", cnt_es - s0, 0);
        check("long_tlast", cnt_last - t0, 4);
        check("long_idle_rdy", S_AXIS_TREADY, 0);

        // zero geometry is ignored
        s0 = cnt_es; l0 = cnt_el;
        fsync(0, 4);
        repeat (4) @(posedge ACLK);
        #1;
        check("zero_w_rdy", S_AXIS_TREADY, 0);
        fsync(4, 0);
        repeat (4) @(posedge ACLK);
        #1;
        check("zero_h_rdy", S_AXIS_TREADY, 0);
        check("zero_err", {cnt_es - s0, cnt_el - l0}, 0);

        // FSYNC together with pixel 7 of a 4x4 frame restarts on that pixel
        d0 = cnt_done; s0 = cnt_es; l0 = cnt_el; t0 = cnt_last;
        fsync(4, 4);
        for (int i = 0; i < 6; i++)
            send_px(32'h0500_0000 + DW'(i), 1'b0, 1'b1, i == 0, (i % 4) == 3);
        S_AXIS_TVALID = 1'b1;
        S_AXIS_TDATA  = 32'h0500_0006;
        S_AXIS_TLAST  = 1'b0;
        FSYNC_IN      = 1'b1;
        @(negedge ACLK);
        check("abort_accept", S_AXIS_TREADY, 1);
        if (S_AXIS_TREADY) exp_q.push_back({32'h0500_0006, 1'b1, 1'b0});
        @(posedge ACLK);
        #1;
        FSYNC_IN = 1'b0;
        for (int j = 1; j < 16; j++)
            send_px(32'h0500_0006 + DW'(j), j == 15, 1'b1, 1'b0, (j % 4) == 3);
        idle_in();
        wait_drain();
        check("abort_es", cnt_es - s0, 1);
        check("abort_el", cnt_el - l0, 0);
        check("abort_done", cnt_done - d0, 1);
        check("abort_tlast", cnt_last - t0, 5);

        // reset mid-frame at 40x40, then a clean frame
        fsync(40, 40);
        run_frame(40, 100, -1, 100, 32'h0600_0000);
        ARESETN = 1'b0;
        #1;
        check("arst_tvalid", M_AXIS_TVALID, 0);
        check("arst_tready", S_AXIS_TREADY, 0);
        exp_q.delete();
        repeat (2) @(posedge ACLK);
        #1;
        ARESETN = 1'b1;
        @(posedge ACLK);
        #1;
        d0 = cnt_done; s0 = cnt_es; l0 = cnt_el; t0 = cnt_last;
        fsync(40, 40);
        run_frame(40, 1600, 1599, 1600, 32'h0700_0000);
        wait_drain();
        check("post_rst_done", cnt_done - d0, 1);
        check("post_rst_tlast", cnt_last - t0, 40);
        check("post_rst_err", {cnt_es - s0, cnt_el - l0}, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
